// File: rtl/frame_ram_pkg.sv
// Shared types and defaults for the frame RAM controller.
// FRAME_RAM_CTRL_FIXED_PRIO_EN (optional) selects fixed read priority in rd_arbiter2.
package frame_ram_pkg;

  localparam int unsigned ROWS_DEF   = 480;
  localparam int unsigned ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SERVE = 2'd3
  } state_t;

  localparam logic REQ_SAD = 1'b0;
  localparam logic REQ_REF = 1'b1;

endpackage

// File: rtl/rd_arbiter2.sv
// Two-way read-port arbiter: round-robin by default, requester 0 always
// favoured when FRAME_RAM_CTRL_FIXED_PRIO_EN is defined.
module rd_arbiter2
  import frame_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] addr_sel
);

`ifdef FRAME_RAM_CTRL_FIXED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    gnt0 = en && req0;
    gnt1 = en && req1 && !req0;
  end
`else
  logic rr_ptr;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = (rr_ptr == REQ_SAD);
        gnt1 = (rr_ptr == REQ_REF);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Favour the other requester after every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= REQ_SAD;
    end else if (gnt0) begin
      rr_ptr <= REQ_REF;
    end else if (gnt1) begin
      rr_ptr <= REQ_SAD;
    end
  end
`endif

  assign addr_sel = gnt1 ? addr1 : addr0;

endmodule

// File: rtl/frame_ram_ctrl.sv
// Frame RAM sequencer: clear, load ROWS lines, then share the read port.
// Build option FRAME_RAM_CTRL_FIXED_PRIO_EN switches the read arbiter to fixed priority.
module frame_ram_ctrl
  import frame_ram_pkg::*;
#(
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              frame_done,
  input  logic              line_valid,
  output logic              line_ready,
  output logic              ram_rst,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic              ram_full,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              frame_ready,
  output logic              addr_err
);

  localparam int unsigned      CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] ROWS_CNT = CNT_W'(ROWS);

  state_t            state;
  logic [CNT_W-1:0]  line_cnt;
  logic [ADDR_W-1:0] addr_sel;
  logic [ADDR_W-1:0] addr_hold;
  logic              serve;
  logic              accept;
  logic              any_gnt;

  assign serve       = (state == ST_SERVE);
  assign frame_ready = serve;
  assign ram_rst     = (state == ST_CLEAR);
  assign line_ready  = (state == ST_LOAD) && (line_cnt < ROWS_CNT);
  assign accept      = line_valid && line_ready;
  assign ram_wr_en   = accept;
  assign any_gnt     = gnt0 || gnt1;

  // Address follows the grant; without a grant the RAM keeps seeing the last row.
  assign ram_read_addr = any_gnt ? addr_sel : addr_hold;

  rd_arbiter2 #(.ADDR_W(ADDR_W)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (serve),
    .req0     (req0),
    .req1     (req1),
    .addr0    (addr0),
    .addr1    (addr1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .addr_sel (addr_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      line_cnt  <= '0;
      addr_hold <= '0;
      addr_err  <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      if (any_gnt) begin
        addr_hold <= addr_sel;
      end
      if (any_gnt && ({1'b0, addr_sel} >= ROWS_CNT)) begin
        addr_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state    <= ST_CLEAR;
            addr_err <= 1'b0;
          end
        end
        ST_CLEAR: begin
          line_cnt <= '0;
          addr_err <= 1'b0;
          state    <= ST_LOAD;
        end
        // ram_full lags the last write by a cycle; it only gates the exit.
        ST_LOAD: begin
          if (accept) begin
            line_cnt <= line_cnt + CNT_W'(1);
          end
          if ((line_cnt == ROWS_CNT) && ram_full) begin
            state <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (frame_start) begin
            state    <= ST_CLEAR;
            addr_err <= 1'b0;
          end else if (frame_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
